en_liner_code: RTL and testbench



---
 rtl/en_liner_code.sv | 104 ++++++++++
 tb/tb_en_liner_code.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/en_liner_code.sv
// Serial-in / serial-out systematic (7,4) linear block encoder.
// Collects d0..d3, appends three check bits, then shifts out c0..c6.
// An optional per-block single-bit flip feeds the decoder's correction path.
module en_liner_code #(
   parameter int PAR_DATA_BITS  = 4,
   parameter int PAR_CODE_LINE  = 7,
   parameter int PAR_CODE_CHECK = 3,
   parameter int PAR_COUNT_W    = 8
) (
   input  logic                   clk_in,
   input  logic                   rst_n,
   input  logic                   data_bit_in,
   input  logic                   data_valid_in,
   output logic                   data_ready_out,
   output logic                   code_bit_out,
   output logic                   code_valid_out,
   input  logic                   code_ready_in,
   output logic                   block_start_out,
   input  logic                   err_en_in,
   input  logic [2:0]             err_pos_in,
   output logic [PAR_COUNT_W-1:0] block_count_out
);

   typedef enum logic [1:0] {COLLECT = 2'd0, ENCODE = 2'd1, EMIT = 2'd2} state_t;

   localparam logic [2:0] LAST_D = 3'(PAR_DATA_BITS - 1);
   localparam logic [2:0] LAST_C = 3'(PAR_CODE_LINE - 1);

   state_t                    state, state_nxt;
   logic [2:0]                cnt;
   logic [PAR_DATA_BITS-1:0]  data_reg;
   logic [PAR_CODE_LINE-1:0]  code_reg;
   logic [PAR_COUNT_W-1:0]    blk_cnt;
   logic [PAR_CODE_CHECK-1:0] chk_bits;
   logic [PAR_CODE_LINE-1:0]  flip_mask;
   logic                      in_acc, out_acc;

   assign in_acc  = (state == COLLECT) && data_valid_in;
   assign out_acc = (state == EMIT) && code_ready_in;

   // Check bits and the optional error mask; only consumed in ENCODE.
   always_comb begin
      chk_bits  = {data_reg[1] ^ data_reg[2] ^ data_reg[3],
                   data_reg[0] ^ data_reg[2] ^ data_reg[3],
                   data_reg[0] ^ data_reg[1] ^ data_reg[3]};
      flip_mask = '0;
      if (err_en_in && (err_pos_in != 3'd7))
         flip_mask[err_pos_in] = 1'b1;
   end

   // State register.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) state <= COLLECT;
      else        state <= state_nxt;
   end

   // Next-state: 4 input beats, one encode cycle, 7 output beats.
   always_comb begin
      state_nxt = state;
      case (state)
         COLLECT: if (in_acc && cnt == LAST_D)  state_nxt = ENCODE;
         ENCODE:                                state_nxt = EMIT;
         EMIT:    if (out_acc && cnt == LAST_C) state_nxt = COLLECT;
         default:                               state_nxt = COLLECT;
      endcase
   end

   // Bit counter, data/code registers and emitted-block counter.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         data_reg <= '0;
         code_reg <= '0;
         blk_cnt  <= '0;
      end else begin
         case (state)
            COLLECT: if (in_acc) begin
               data_reg[cnt[1:0]] <= data_bit_in;
               cnt                <= (cnt == LAST_D) ? 3'd0 : cnt + 3'd1;
            end
            ENCODE: code_reg <= {chk_bits, data_reg} ^ flip_mask;
            EMIT: if (out_acc) begin
               if (cnt == LAST_C) begin
                  cnt     <= 3'd0;
                  blk_cnt <= blk_cnt + 1'b1;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

   // Outputs decode state and registers only; no input reaches an output.
   always_comb begin
      data_ready_out  = (state == COLLECT);
      code_valid_out  = (state == EMIT);
      block_start_out = (state == EMIT) && (cnt == 3'd0);
      code_bit_out    = code_reg[cnt];
      block_count_out = blk_cnt;
   end

endmodule

// File: tb/tb_en_liner_code.sv
// Directed bench for en_liner_code: known codewords, error injection,
// backpressure, mid-block reset and ignored input during emission.
module tb_en_liner_code;

   logic       clk_in = 1'b0;
   logic       rst_n;
   logic       data_bit_in, data_valid_in, data_ready_out;
   logic       code_bit_out, code_valid_out, code_ready_in, block_start_out;
   logic       err_en_in;
   logic [2:0] err_pos_in;
   logic [7:0] block_count_out;

   int n_tests = 0;
   int n_fail  = 0;
   int low_cyc = 0;

   en_liner_code dut (
      .clk_in(clk_in), .rst_n(rst_n),
      .data_bit_in(data_bit_in), .data_valid_in(data_valid_in),
      .data_ready_out(data_ready_out),
      .code_bit_out(code_bit_out), .code_valid_out(code_valid_out),
      .code_ready_in(code_ready_in), .block_start_out(block_start_out),
      .err_en_in(err_en_in), .err_pos_in(err_pos_in),
      .block_count_out(block_count_out)
   );

   always #5 clk_in = ~clk_in;

   // Cycles with the input side closed, sampled mid-cycle.
   always @(negedge clk_in) if (rst_n && !data_ready_out) low_cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entered and left on a falling edge; leaves with the FSM in ENCODE.
   task automatic send_block(input logic [3:0] d);
      for (int i = 0; i < 4; i++) begin
         chk("data_ready", data_ready_out, 1'b1);
         data_valid_in = 1'b1;
         data_bit_in   = d[i];
         @(negedge clk_in);
      end
      data_valid_in = 1'b0;
      chk("encode_ready", data_ready_out, 1'b0);
      chk("encode_valid", code_valid_out, 1'b0);
   endtask

   // Receives bits lo..hi of codeword exp (bit0 = c0) with ready held high.
   task automatic recv_bits(input logic [6:0] exp, input int lo, input int hi,
                            input bit noise, input string tag);
      for (int j = lo; j <= hi; j++) begin
         int t = 0;
         while (!code_valid_out && t < 20) begin
            @(negedge clk_in);
            t++;
         end
         chk({tag, "_valid"}, code_valid_out, 1'b1);
         chk({tag, "_bit"},   code_bit_out,   exp[j]);
         chk({tag, "_start"}, block_start_out, (j == 0));
         if (noise) begin
            data_valid_in = 1'($urandom);
            data_bit_in   = 1'($urandom);
         end
         @(negedge clk_in);
      end
      data_valid_in = 1'b0;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(negedge clk_in);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; data_bit_in = 1'b0; data_valid_in = 1'b0;
      code_ready_in = 1'b1; err_en_in = 1'b0; err_pos_in = 3'd0;
      #2;
      chk("rst_ready", data_ready_out, 1'b1);
      chk("rst_valid", code_valid_out, 1'b0);
      chk("rst_bit",   code_bit_out,   1'b0);
      chk("rst_start", block_start_out, 1'b0);
      chk("rst_count", block_count_out, 8'd0);
      @(negedge clk_in); @(negedge clk_in);
      rst_n = 1'b1;
      @(negedge clk_in);

      // 1,0,1,1 -> 1,0,1,1,0,1,0
      send_block(4'b1101);
      recv_bits(7'b0101101, 0, 6, 1'b0, "t1");
      chk("t1_count", block_count_out, 8'd1);
      chk("t1_ready", data_ready_out, 1'b1);

      // back-to-back all-zero / all-one blocks from a fresh reset
      pulse_reset();
      low_cyc = 0;
      send_block(4'b0000);
      recv_bits(7'b0000000, 0, 6, 1'b0, "t2a");
      chk("t2a_low", low_cyc, 8);
      chk("t2a_count", block_count_out, 8'd1);
      low_cyc = 0;
      send_block(4'b1111);
      recv_bits(7'b1111111, 0, 6, 1'b0, "t2b");
      chk("t2b_low", low_cyc, 8);
      chk("t2b_count", block_count_out, 8'd2);

      // error injection at c2, then position 7 (no flip)
      send_block(4'b1101);
      err_en_in = 1'b1; err_pos_in = 3'd2;
      @(negedge clk_in);
      err_en_in = 1'b0; err_pos_in = 3'd0;
      recv_bits(7'b0101001, 0, 6, 1'b0, "t3a");
      err_en_in = 1'b1; err_pos_in = 3'd7;   // held through COLLECT: ignored there
      send_block(4'b1101);
      @(negedge clk_in);
      err_en_in = 1'b0; err_pos_in = 3'd0;
      recv_bits(7'b0101101, 0, 6, 1'b0, "t3b");
      chk("t3_count", block_count_out, 8'd4);

      // stall for 3 cycles while c3 is presented
      send_block(4'b1101);
      recv_bits(7'b0101101, 0, 2, 1'b0, "t4a");
      code_ready_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("t4_hold_valid", code_valid_out, 1'b1);
         chk("t4_hold_bit",   code_bit_out,   1'b1);
         chk("t4_hold_start", block_start_out, 1'b0);
         @(negedge clk_in);
      end
      code_ready_in = 1'b1;
      recv_bits(7'b0101101, 3, 6, 1'b0, "t4b");
      chk("t4_count", block_count_out, 8'd5);

      // reset after 3 output beats discards the block
      send_block(4'b1101);
      recv_bits(7'b0101101, 0, 2, 1'b0, "t5a");
      rst_n = 1'b0;
      #1;
      chk("t5_rst_ready", data_ready_out, 1'b1);
      chk("t5_rst_valid", code_valid_out, 1'b0);
      chk("t5_rst_bit",   code_bit_out,   1'b0);
      chk("t5_rst_start", block_start_out, 1'b0);
      chk("t5_rst_count", block_count_out, 8'd0);
      @(negedge clk_in);
      rst_n = 1'b1;
      send_block(4'b1111);
      recv_bits(7'b1111111, 0, 6, 1'b0, "t5b");
      chk("t5_count", block_count_out, 8'd1);

      // random data_valid_in during emission must not be taken
      send_block(4'b1101);
      recv_bits(7'b0101101, 0, 6, 1'b1, "t6a");
      send_block(4'b0110);
      recv_bits(7'b0110110, 0, 6, 1'b0, "t6b");
      chk("t6_count", block_count_out, 8'd3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
